// File: rtl/store_size_unit.sv
// ---------------------------------------------------------------------------
// store_size_unit
//
// Performs sw / sh / sb stores against a single-port data memory. Full-word
// stores are written straight away. Halfword and byte stores read the target
// word, replace the selected lane, and write the merged word back. The
// control unit stalls while busy is high and resumes on the done pulse.
//
// Parameters
//   MEM_LATENCY : cycles from mem_addr presented to mem_rdata valid (1..7)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   request strobe, sampled only in IDLE
//   store_type in   00 = sw, 01 = sh, 10 = sb, 11 = reserved
//   addr       in   byte address of the store
//   reg_data   in   register value (sh uses [15:0], sb uses [7:0])
//   mem_rdata  in   memory read data
//   mem_addr   out  word-aligned memory address
//   mem_wr     out  memory write enable (high only in WRITE)
//   mem_wdata  out  word written to memory
//   busy       out  high in every non-IDLE state
//   done       out  one-cycle pulse when the store completes
//   store_err  out  one-cycle pulse on misaligned address or reserved type
// ---------------------------------------------------------------------------
module store_size_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        store_err
);

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [1:0]  type_q;
    logic [1:0]  lane_q;
    logic [15:0] data_q;
    logic        start_err;

    // Replace only the addressed lane of the fetched word; the remaining
    // lanes are passed through untouched (little-endian lane numbering).
    function automatic logic [31:0] merge_lane(
        input logic [31:0] word,
        input logic [1:0]  st,
        input logic [1:0]  lane,
        input logic [15:0] data
    );
        logic [31:0] r;
        r = word;
        if (st == ST_SH) begin
            if (lane[1]) r[31:16] = data;
            else         r[15:0]  = data;
        end else begin
            case (lane)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end
        return r;
    endfunction

    always_comb begin
        start_err = 1'b0;
        if (store_type == 2'b11)                         start_err = 1'b1;
        else if (store_type == ST_SW && addr[1:0] != 2'b00) start_err = 1'b1;
        else if (store_type == ST_SH && addr[0])         start_err = 1'b1;
    end

    // All outputs are registered alongside the state transition, so mem_wr,
    // busy, done and store_err each track exactly one state and cannot glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            type_q    <= '0;
            lane_q    <= '0;
            data_q    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            store_err <= 1'b0;
        end else begin
            mem_wr    <= 1'b0;
            done      <= 1'b0;
            store_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        type_q   <= store_type;
                        lane_q   <= addr[1:0];
                        data_q   <= reg_data[15:0];
                        mem_addr <= {addr[31:2], 2'b00};
                        busy     <= 1'b1;
                        if (start_err) begin
                            state     <= S_ERR;
                            store_err <= 1'b1;
                        end else if (store_type == ST_SW) begin
                            state     <= S_WRITE;
                            mem_wr    <= 1'b1;
                            mem_wdata <= reg_data;
                        end else begin
                            state <= S_READ;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_READ: begin
                    // Hold the address until the read data has had
                    // MEM_LATENCY cycles to arrive.
                    if (cnt != 3'd0) cnt   <= cnt - 3'd1;
                    else             state <= S_CAPT;
                end
                S_CAPT: begin
                    mem_wdata <= merge_lane(mem_rdata, type_q, lane_q, data_q);
                    mem_wr    <= 1'b1;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_size_unit.sv
module tb_store_size_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start1, start3, mem_init;
    logic [1:0]  store_type;
    logic [31:0] addr, reg_data;

    logic [31:0] rd1, ma1, wd1;
    logic        mw1, busy1, done1, err1;
    logic [31:0] rd3, ma3, wd3;
    logic        mw3, busy3, done3, err3;

    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] p3a, p3b, p3c;

    int n_cmp = 0;
    int n_err = 0;

    store_size_unit #(.MEM_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .store_type(store_type),
        .addr(addr), .reg_data(reg_data), .mem_rdata(rd1),
        .mem_addr(ma1), .mem_wr(mw1), .mem_wdata(wd1),
        .busy(busy1), .done(done1), .store_err(err1)
    );

    store_size_unit #(.MEM_LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .start(start3), .store_type(store_type),
        .addr(addr), .reg_data(reg_data), .mem_rdata(rd3),
        .mem_addr(ma3), .mem_wr(mw3), .mem_wdata(wd3),
        .busy(busy3), .done(done3), .store_err(err3)
    );

    // Memory models: 1-cycle and 3-cycle read latency.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= 32'h11223344;
                mem3[i] <= 32'h11223344;
            end
        end else begin
            if (mw1) mem1[ma1[5:2]] <= wd1;
            if (mw3) mem3[ma3[5:2]] <= wd3;
        end
        rd1 <= mem1[ma1[5:2]];
        p3a <= mem3[ma3[5:2]];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign rd3 = p3c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Present a request for one edge, then scramble the inputs to show they
    // are latched. Returns at the sample point of the first non-IDLE cycle.
    task automatic go(input bit use3, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        store_type = t;
        addr       = a;
        reg_data   = d;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1     = 1'b0;
        start3     = 1'b0;
        store_type = 2'b11;
        addr       = 32'hFFFF_FFFF;
        reg_data   = 32'h5555_5555;
    endtask

    task automatic reinit();
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
    endtask

    logic [1:0]  et [3];
    logic [31:0] ea [3];

    initial begin
        reset = 1'b0; mem_init = 1'b1; start1 = 1'b0; start3 = 1'b0;
        store_type = 2'b00; addr = '0; reg_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_wr", mw1, 0);
        chk("rst_done", done1, 0);
        chk("rst_err", err1, 0);
        chk("rst_addr", ma1, 0);
        chk("rst_wdata", wd1, 0);
        chk("rst_busy3", busy3, 0);
        reset = 1'b1; mem_init = 1'b0;
        @(negedge clk);

        // sw 0x10
        go(0, 2'b00, 32'h10, 32'hDEADBEEF);
        chk("sw_c1_wr", mw1, 1);
        chk("sw_c1_addr", ma1, 32'h10);
        chk("sw_c1_wdata", wd1, 32'hDEADBEEF);
        chk("sw_c1_done", done1, 0);
        @(negedge clk);
        chk("sw_c2_done", done1, 1);
        chk("sw_c2_wr", mw1, 0);
        chk("sw_c2_busy", busy1, 1);
        @(negedge clk);
        chk("sw_c3_busy", busy1, 0);
        chk("sw_mem", mem1[4], 32'hDEADBEEF);

        // sh 0x22, started in the first IDLE cycle after DONE
        go(0, 2'b01, 32'h22, 32'hFFFFBEEF);
        chk("sh22_c1_busy", busy1, 1);
        chk("sh22_c1_wr", mw1, 0);
        chk("sh22_c1_addr", ma1, 32'h20);
        @(negedge clk);
        chk("sh22_c2_wr", mw1, 0);
        @(negedge clk);
        chk("sh22_c3_wr", mw1, 1);
        chk("sh22_c3_wdata", wd1, 32'hBEEF3344);
        @(negedge clk);
        chk("sh22_c4_done", done1, 1);
        @(negedge clk);
        chk("sh22_c5_busy", busy1, 0);
        chk("sh22_mem", mem1[8], 32'hBEEF3344);

        // sb 0x13
        reinit();
        go(0, 2'b10, 32'h13, 32'h000000AB);
        chk("sb_c1_wr", mw1, 0);
        @(negedge clk);
        chk("sb_c2_wr", mw1, 0);
        chk("sb_c2_done", done1, 0);
        @(negedge clk);
        chk("sb_c3_wr", mw1, 1);
        chk("sb_c3_wdata", wd1, 32'hAB223344);
        @(negedge clk);
        chk("sb_c4_done", done1, 1);
        chk("sb_c4_wr", mw1, 0);
        @(negedge clk);
        chk("sb_c5_busy", busy1, 0);
        chk("sb_c5_done", done1, 0);
        chk("sb_mem", mem1[4], 32'hAB223344);

        // sh 0x20 on a fresh word
        reinit();
        go(0, 2'b01, 32'h20, 32'hFFFFBEEF);
        repeat (2) @(negedge clk);
        chk("sh20_c3_wr", mw1, 1);
        chk("sh20_c3_wdata", wd1, 32'h1122BEEF);
        @(negedge clk);
        chk("sh20_c4_done", done1, 1);
        @(negedge clk);

        // error cases
        et[0] = 2'b01; ea[0] = 32'h21;
        et[1] = 2'b00; ea[1] = 32'h22;
        et[2] = 2'b11; ea[2] = 32'h20;
        for (int i = 0; i < 3; i++) begin
            go(0, et[i], ea[i], 32'h12345678);
            chk($sformatf("err%0d_c1_err", i), err1, 1);
            chk($sformatf("err%0d_c1_busy", i), busy1, 1);
            chk($sformatf("err%0d_c1_wr", i), mw1, 0);
            @(negedge clk);
            chk($sformatf("err%0d_c2_err", i), err1, 0);
            chk($sformatf("err%0d_c2_busy", i), busy1, 0);
            chk($sformatf("err%0d_c2_wr", i), mw1, 0);
            chk($sformatf("err%0d_c2_done", i), done1, 0);
        end

        // reset during READ of an sb
        reinit();
        go(0, 2'b10, 32'h13, 32'h000000AB);
        chk("rr_c1_busy", busy1, 1);
        #2 reset = 1'b0;
        #1;
        chk("rr_async_busy", busy1, 0);
        chk("rr_async_wr", mw1, 0);
        chk("rr_async_done", done1, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rr_after_busy", busy1, 0);
        chk("rr_after_wr", mw1, 0);
        chk("rr_after_addr", ma1, 0);
        chk("rr_mem", mem1[4], 32'h11223344);

        // MEM_LATENCY = 3, sb 0x01, with an ignored start while busy
        reinit();
        go(1, 2'b10, 32'h01, 32'h000000CD);
        chk("l3_c1_busy", busy3, 1);
        chk("l3_c1_wr", mw3, 0);
        chk("l3_c1_addr", ma3, 32'h0);
        store_type = 2'b00; addr = 32'h4; reg_data = 32'h0; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("l3_c2_wr", mw3, 0);
        chk("l3_c2_busy", busy3, 1);
        chk("l3_c2_addr", ma3, 32'h0);
        @(negedge clk);
        chk("l3_c3_wr", mw3, 0);
        @(negedge clk);
        chk("l3_c4_wr", mw3, 0);
        @(negedge clk);
        chk("l3_c5_wr", mw3, 1);
        chk("l3_c5_wdata", wd3, 32'h1122CD44);
        chk("l3_c5_done", done3, 0);
        @(negedge clk);
        chk("l3_c6_done", done3, 1);
        @(negedge clk);
        chk("l3_c7_busy", busy3, 0);
        chk("l3_mem0", mem3[0], 32'h1122CD44);
        @(negedge clk);
        chk("l3_c8_busy", busy3, 0);
        chk("l3_mem1", mem3[1], 32'h11223344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_size_unit.md
Name: store_size_unit

Overview:
Write-side counterpart of the write-back select path. It takes register data plus a store type (sw/sh/sb) and performs the memory store. Full-word stores are written directly. Byte and halfword stores run a read-modify-write sequence against the single-port data memory. Sits between the control unit and the memory port; the control unit stalls on busy and resumes on done.

Parameters:
MEM_LATENCY, 1, cycles from mem_addr presented (read) to mem_rdata valid; legal range 1..7.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request strobe; sampled only in IDLE.
store_type  input  2  00 = sw, 01 = sh, 10 = sb, 11 = reserved.
addr  input  32  byte address of the store.
reg_data  input  32  register value to store; sh uses bits [15:0], sb uses bits [7:0].
mem_rdata  input  32  memory read data.
mem_addr  output  32  word-aligned memory address, {addr[31:2], 2'b00}.
mem_wr  output  1  memory write enable.
mem_wdata  output  32  word written to memory.
busy  output  1  high in every non-IDLE state.
done  output  1  one-cycle pulse when the store completes.
store_err  output  1  one-cycle pulse on a misaligned address or reserved type; no write is performed.

Behaviour:
- Reset (reset = 0): FSM goes to IDLE immediately. mem_addr, mem_wdata and the internal latches clear to 0. mem_wr, busy, done and store_err go to 0 asynchronously. A reset mid-sequence abandons the store with no write.
- Lane map (little-endian):
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - halfword h = addr[1] occupies bits [16h+15:16h].
- Start: in IDLE with start = 1 at a rising edge, latch addr, store_type and reg_data. Later changes to these inputs are ignored until IDLE is re-entered. start outside IDLE is ignored.
- Checks, made at start:
  - type 11 is an error;
  - sw with addr[1:0] != 00 is an error;
  - sh with addr[0] = 1 is an error.
  - On an error: go to ERR, pulse store_err for 1 cycle, return to IDLE. mem_wr stays 0.
- States: IDLE, READ, CAPT, WRITE, DONE, ERR.
  - sw: IDLE -> WRITE -> DONE -> IDLE.
  - sh/sb: IDLE -> READ -> CAPT -> WRITE -> DONE -> IDLE.
- READ: mem_addr driven; a counter loads MEM_LATENCY-1. Stay in READ while the counter != 0, decrementing each cycle.
- CAPT: register mem_rdata into an internal word. This is the cycle MEM_LATENCY after the first READ cycle.
- WRITE: mem_wr = 1 for exactly one cycle.
  - sw: mem_wdata = latched reg_data.
  - sh/sb: mem_wdata = captured word with only the selected lane replaced by reg_data[15:0] or reg_data[7:0]; all other lanes are unchanged.
- DONE: done = 1 for one cycle; busy is still 1.
- mem_addr is stable from the first non-IDLE cycle through DONE.
- mem_wr is decoded from state only (glitch-free Moore output) and is never high outside WRITE.
- Latency, counted from the start edge to the done cycle:
  - sw: 2 cycles;
  - sb/sh: 3 + MEM_LATENCY cycles (4 at default).
- A new start is accepted in the cycle after DONE, since IDLE is re-entered then.

Test Plan:
- sw, addr = 0x0000_0010, reg_data = 0xDEADBEEF -> cycle 1: mem_wr = 1, mem_addr = 0x10, mem_wdata = 0xDEADBEEF; cycle 2: done = 1; no read cycle occurs.
- sb, addr = 0x0000_0013, reg_data = 0x0000_00AB, memory word = 0x11223344 (MEM_LATENCY = 1) -> one WRITE with mem_wdata = 0xAB223344; done at cycle 4.
- sh, addr = 0x0000_0022, reg_data = 0xFFFF_BEEF, memory word = 0x11223344 -> mem_wdata = 0xBEEF3344; sh at addr 0x20 on the same word -> 0x1122BEEF.
- Errors: sh at 0x21, sw at 0x22, type 11 at 0x20 -> each gives a store_err pulse of 1 cycle, mem_wr never asserted, busy high for 1 cycle only.
- reset driven low during READ of an sb -> mem_wr, busy and done are 0 immediately; after release the FSM is in IDLE, and memory is unchanged.
- MEM_LATENCY = 3, sb at 0x01 on word 0x11223344 with reg_data = 0x000000CD -> capture occurs 3 cycles after the first READ cycle, mem_wdata = 0x1122CD44, done at cycle 6; a start pulsed while busy is ignored.
